// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one FP multiplier among NUM_REQ requesters.
// Sequences the start/done/serv handshake and returns a product or a timeout error.
module fp_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_op1,
  input  logic [32*NUM_REQ-1:0]   req_op2,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [31:0]             resp_result,
  output logic                    resp_err,
  output logic                    arb_busy,
  output logic                    mul_start,
  output logic [31:0]             mul_op1,
  output logic [31:0]             mul_op2,
  output logic                    mul_serv,
  input  logic [31:0]             mul_result,
  input  logic                    mul_done,
  input  logic                    mul_busy
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_RETURN = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_winner;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_result;
  logic          r_err;
  logic [31:0]   r_op1;
  logic [31:0]   r_op2;

  logic          w_found;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_ptr_nxt;
  logic          w_grant;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_cap_res;
  logic [31:0]   w_res_val;
  logic          w_err_val;

  // First requesting slot at or after the round-robin pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_idx = IW'((32'(r_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_ptr_nxt = ((32'(w_win) + 32'd1) == NUM_REQ) ? '0 : IW'(32'(w_win) + 32'd1);
  assign w_grant   = (r_state == S_IDLE) && w_found && !mul_done && !mul_busy && !rst;
  assign w_cnt_nxt = r_cnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, result capture and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cap_res   = 1'b0;
    w_res_val   = '0;
    w_err_val   = 1'b0;
    req_ready   = '0;
    resp_valid  = '0;
    resp_result = '0;
    resp_err    = 1'b0;
    arb_busy    = 1'b1;
    mul_start   = 1'b0;
    mul_serv    = 1'b0;
    case (r_state)
      S_IDLE: begin
        arb_busy = 1'b0;
        if (w_grant) begin
          req_ready   = NUM_REQ'(1) << w_win;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_start   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mul_done) begin
          w_cap_res   = 1'b1;
          w_res_val   = mul_result;
          w_state_nxt = S_RETURN;
        end else if (w_cnt_nxt == CW'(TIMEOUT)) begin
          w_cap_res   = 1'b1;
          w_err_val   = 1'b1;
          w_state_nxt = S_RETURN;
        end
      end
      S_RETURN: begin
        resp_valid  = NUM_REQ'(1) << r_winner;
        resp_result = r_result;
        resp_err    = r_err;
        mul_serv    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand latch, pointer advance, wait counter and captured response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr    <= '0;
      r_winner <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
    end else begin
      if (w_grant) begin
        r_op1    <= req_op1[{w_win, 5'b0} +: 32];
        r_op2    <= req_op2[{w_win, 5'b0} +: 32];
        r_winner <= w_win;
        r_ptr    <= w_ptr_nxt;
      end
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= w_cnt_nxt;
      if (w_cap_res) begin
        r_result <= w_res_val;
        r_err    <= w_err_val;
      end
    end
  end

  assign mul_op1 = r_op1;
  assign mul_op2 = r_op2;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed self-checking bench for fp_mul_arbiter with a latency-programmable multiplier model.
module tb_fp_mul_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_op1 = '0;
  logic [127:0] req_op2 = '0;
  logic [3:0]   req_ready;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_result;
  logic         resp_err;
  logic         arb_busy;
  logic         mul_start;
  logic [31:0]  mul_op1;
  logic [31:0]  mul_op2;
  logic         mul_serv;
  logic [31:0]  mul_result;
  logic         mul_done;
  logic         mul_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] op1_tab [4];
  logic [31:0] op2_tab [4];

  int          m_lat   = 6;
  bit          m_never = 1'b0;
  int          m_cnt;
  logic        m_busy, m_done;
  logic [31:0] m_res;

  fp_mul_arbiter #(.NUM_REQ(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_err(resp_err), .arb_busy(arb_busy),
    .mul_start(mul_start), .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_serv(mul_serv),
    .mul_result(mul_result), .mul_done(mul_done), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hand-computed products for the operand pairs used below.
  function automatic logic [31:0] fmul_tab(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: return 32'h40000000;
      64'h3FC00000_3FC00000: return 32'h40100000;
      64'h40000000_40000000: return 32'h40800000;
      64'h40400000_40000000: return 32'h40C00000;
      64'h40800000_40000000: return 32'h41000000;
      64'h3F000000_40000000: return 32'h3F800000;
      default:               return 32'hDEADBEEF;
    endcase
  endfunction

  // Multiplier model: done m_lat cycles after the start cycle, held until serv.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_res <= '0;
    end else if (mul_serv) begin
      m_busy <= 1'b0; m_done <= 1'b0;
    end else if (mul_start) begin
      m_busy <= 1'b1; m_cnt <= m_lat - 1; m_res <= fmul_tab(mul_op1, mul_op2);
    end else if (m_busy && !m_never) begin
      if (m_cnt == 1) begin m_done <= 1'b1; m_busy <= 1'b0; end
      else m_cnt <= m_cnt - 1;
    end
  end
  assign mul_done   = m_done;
  assign mul_busy   = m_busy;
  assign mul_result = m_done ? m_res : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (mul_start === 1'b1) chk("start_while_done", 32'(mul_done), 32'h0);

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      req_op1[32*i +: 32] = op1_tab[i];
      req_op2[32*i +: 32] = op2_tab[i];
    end
  endtask

  // One transaction from a negedge: grant, issue, then response after exp_lat cycles.
  task automatic do_txn(input logic [3:0] valid, input int exp_slot, input logic [31:0] exp_res,
                        input logic exp_err, input int exp_lat, input bit hold);
    bit got = 1'b0;
    int lat = 0;
    req_valid = valid;
    for (int c = 0; c < 20 && !got; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req_ready != 4'b0) got = 1'b1;
    end
    chk("grant_seen", 32'(got), 32'h1);
    chk("req_ready", 32'(req_ready), 32'(4'b0001 << exp_slot));
    @(negedge clk);
    if (!hold) req_valid = '0;
    #1;
    chk("mul_start", 32'(mul_start), 32'h1);
    chk("mul_op1", mul_op1, op1_tab[exp_slot]);
    chk("mul_op2", mul_op2, op2_tab[exp_slot]);
    got = 1'b0;
    lat = 1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      lat++;
      #1;
      if (resp_valid != 4'b0) got = 1'b1;
    end
    chk("resp_seen", 32'(got), 32'h1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("resp_valid", 32'(resp_valid), 32'(4'b0001 << exp_slot));
    chk("resp_result", resp_result, exp_res);
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    chk("mul_serv", 32'(mul_serv), 32'h1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_rvalid"}, 32'(resp_valid), 32'h0);
    chk({tag, "_result"}, resp_result, 32'h0);
    chk({tag, "_err"}, 32'(resp_err), 32'h0);
    chk({tag, "_busy"}, 32'(arb_busy), 32'h0);
    chk({tag, "_start"}, 32'(mul_start), 32'h0);
    chk({tag, "_op1"}, mul_op1, 32'h0);
    chk({tag, "_op2"}, mul_op2, 32'h0);
    chk({tag, "_serv"}, 32'(mul_serv), 32'h0);
  endtask

  initial begin
    bit got;
    #2;
    chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Single request on slot 0: 1.0 * 2.0
    op1_tab = '{32'h3F800000, 32'h0, 32'h0, 32'h0};
    op2_tab = '{32'h40000000, 32'h0, 32'h0, 32'h0};
    load_ops();
    do_txn(4'b0001, 0, 32'h40000000, 1'b0, 8, 1'b0);
    @(negedge clk); #1;
    chk("idle_after_return", 32'(arb_busy), 32'h0);

    // Slot 2: 1.5 * 1.5
    op1_tab = '{32'h0, 32'h0, 32'h3FC00000, 32'h0};
    op2_tab = '{32'h0, 32'h0, 32'h3FC00000, 32'h0};
    load_ops();
    @(negedge clk);
    do_txn(4'b0100, 2, 32'h40100000, 1'b0, 8, 1'b0);

    // Pointer wrap: grant 3, then 1001 -> 0 then 3
    op1_tab = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h3F000000};
    op2_tab = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    load_ops();
    @(negedge clk);
    do_txn(4'b1000, 3, 32'h3F800000, 1'b0, 8, 1'b0);
    @(negedge clk);
    do_txn(4'b1001, 0, 32'h40800000, 1'b0, 8, 1'b1);
    do_txn(4'b1001, 3, 32'h3F800000, 1'b0, 8, 1'b0);

    // Contention with all four held: 0,1,2,3,0
    @(negedge clk);
    do_txn(4'b1111, 0, 32'h40800000, 1'b0, 8, 1'b1);
    do_txn(4'b1111, 1, 32'h40C00000, 1'b0, 8, 1'b1);
    do_txn(4'b1111, 2, 32'h41000000, 1'b0, 8, 1'b1);
    do_txn(4'b1111, 3, 32'h3F800000, 1'b0, 8, 1'b1);
    do_txn(4'b1111, 0, 32'h40800000, 1'b0, 8, 1'b0);

    // Timeout: done never arrives -> RETURN after 15 WAIT cycles
    m_never = 1'b1;
    @(negedge clk);
    do_txn(4'b0010, 1, 32'h0, 1'b1, 17, 1'b0);
    m_never = 1'b0;

    // Done in the final WAIT cycle wins over the timeout
    m_lat = 15;
    @(negedge clk);
    do_txn(4'b0100, 2, 32'h41000000, 1'b0, 17, 1'b0);
    m_lat = 6;

    // Reset in WAIT: outputs clear asynchronously, no response, pointer back to 0
    @(negedge clk);
    req_valid = 4'b0010;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req_ready != 4'b0) got = 1'b1;
    end
    chk("rst_grant", 32'(req_ready), 32'h2);
    @(negedge clk); req_valid = '0;
    @(negedge clk); @(negedge clk);
    req_valid = 4'b1111;
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    req_valid = '0;
    rst = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); #1;
      if (resp_valid != 4'b0) got = 1'b1;
    end
    chk("no_resp_after_rst", 32'(got), 32'h0);
    do_txn(4'b1111, 0, 32'h40800000, 1'b0, 8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
